// File: rtl/red_iterativa_izq_der.sv
// Registered MSB-to-LSB iterative magnitude comparator (K cells).
// Optional bit-serial trace port enabled by RED_ITERATIVA_SERIAL_EN.
module red_iterativa_izq_der #(
  parameter int K = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  output logic [K-1:0] M,
  output logic [K-1:0] N,
  output logic         Z,
  output logic         out_valid
`ifdef RED_ITERATIVA_SERIAL_EN
  ,
  output logic         A_t,
  output logic         B_t,
  output logic         Z_t,
  output logic         scan_busy
`endif
);

  logic [K-1:0] m_d, n_d;
  logic [K-1:0] m_q, n_q;
  logic         z_q, ov_q;

  // Scalar carries avoid a self-referencing vector in the chain.
  always_comb begin
    logic mc, nc, mn, nn;
    mc = 1'b0;
    nc = 1'b0;
    m_d = '0;
    n_d = '0;
    for (int i = K - 1; i >= 0; i--) begin
      mn = mc | (~nc & A[i] & ~B[i]);
      nn = nc | (~mc & ~A[i] & B[i]);
      mc = mn;
      nc = nn;
      m_d[i] = mc;
      n_d[i] = nc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q  <= '0;
      n_q  <= '0;
      z_q  <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      ov_q <= in_valid;
      if (in_valid) begin
        m_q <= m_d;
        n_q <= n_d;
        z_q <= m_d[0];
      end
    end
  end

  assign M         = m_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign out_valid = ov_q;

`ifdef RED_ITERATIVA_SERIAL_EN
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  logic [K-1:0]  a_cap_q, b_cap_q;
  logic [IW-1:0] idx_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_cap_q <= '0;
      b_cap_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else if (in_valid) begin
      a_cap_q <= A;
      b_cap_q <= B;
      idx_q   <= IW'(K - 1);
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      if (idx_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  assign A_t       = busy_q & a_cap_q[idx_q];
  assign B_t       = busy_q & b_cap_q[idx_q];
  assign Z_t       = busy_q & n_q[idx_q];
  assign scan_busy = busy_q;
`endif

endmodule

// File: tb/tb_red_iterativa_izq_der.sv
// Randomized bench for red_iterativa_izq_der against a magnitude model.
// Trace checks are compiled in when RED_ITERATIVA_SERIAL_EN is defined.
module tb_red_iterativa_izq_der;

  localparam int K = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [K-1:0] A, B;
  logic [K-1:0] M, N;
  logic         Z, out_valid;
`ifdef RED_ITERATIVA_SERIAL_EN
  logic A_t, B_t, Z_t, scan_busy;
`endif

  red_iterativa_izq_der #(.K(K)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .A(A),
    .B(B),
    .M(M),
    .N(N),
    .Z(Z),
    .out_valid(out_valid)
`ifdef RED_ITERATIVA_SERIAL_EN
    ,
    .A_t(A_t),
    .B_t(B_t),
    .Z_t(Z_t),
    .scan_busy(scan_busy)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [K-1:0] exp_m = '0, exp_n = '0;
  logic         exp_z = 1'b0, exp_ov = 1'b0;
  logic [K-1:0] cap_a = '0, cap_b = '0;
  int           scan_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Flags fill every position at and below the first differing bit.
  task automatic ref_mn(input logic [K-1:0] a, input logic [K-1:0] b,
                        output logic [K-1:0] m, output logic [K-1:0] n);
    int p;
    logic [K-1:0] mask;
    m = '0;
    n = '0;
    p = -1;
    for (int i = 0; i < K; i++)
      if (a[i] != b[i]) p = i;
    if (p >= 0) begin
      mask = K'((64'd1 << (p + 1)) - 64'd1);
      if (a > b) m = mask;
      else n = mask;
    end
  endtask

  task automatic tick(input logic r, input logic v,
                      input logic [K-1:0] a, input logic [K-1:0] b);
    reset = r;
    in_valid = v;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    if (r) begin
      exp_m = '0;
      exp_n = '0;
      exp_z = 1'b0;
      exp_ov = 1'b0;
      scan_q.delete();
    end else begin
      exp_ov = v;
      if (v) begin
        ref_mn(a, b, exp_m, exp_n);
        exp_z = (a > b);
        cap_a = a;
        cap_b = b;
        scan_q.delete();
        for (int i = K - 1; i >= 0; i--) scan_q.push_back(i);
      end else if (scan_q.size() > 0) begin
        void'(scan_q.pop_front());
      end
    end
    chk("M", 32'(M), 32'(exp_m));
    chk("N", 32'(N), 32'(exp_n));
    chk("Z", 32'(Z), 32'(exp_z));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
`ifdef RED_ITERATIVA_SERIAL_EN
    if (scan_q.size() > 0) begin
      chk("A_t", 32'(A_t), 32'(cap_a[scan_q[0]]));
      chk("B_t", 32'(B_t), 32'(cap_b[scan_q[0]]));
      chk("Z_t", 32'(Z_t), 32'(exp_n[scan_q[0]]));
      chk("scan_busy", 32'(scan_busy), 32'd1);
    end else begin
      chk("trace_idle", {28'd0, A_t, B_t, Z_t, scan_busy}, 32'd0);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;

    tick(1, 0, 5'b00000, 5'b00000);
    tick(1, 0, 5'b00000, 5'b00000);
    tick(0, 0, 5'b00000, 5'b00000);
    chk("rst_M", 32'(M), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);

    tick(0, 1, 5'b10110, 5'b10011);
    chk("dir1_M", 32'(M), 32'b00111);
    chk("dir1_Z", 32'(Z), 32'd1);
    tick(0, 0, 5'b00000, 5'b11111);
    chk("dir1_hold_M", 32'(M), 32'b00111);

    tick(0, 1, 5'b01001, 5'b01100);
    chk("dir2_N", 32'(N), 32'b00111);
    tick(0, 1, 5'b10101, 5'b10101);
    chk("eq_MN", 32'({M, N}), 32'd0);

    tick(0, 1, 5'b11111, 5'b00000);
    chk("ext1_M", 32'(M), 32'b11111);
    tick(0, 1, 5'b00000, 5'b11111);
    chk("ext2_N", 32'(N), 32'b11111);
    chk("ext2_ov", 32'(out_valid), 32'd1);

    tick(0, 1, 5'b10110, 5'b10011);
    tick(1, 0, 5'b00000, 5'b00000);
    chk("rst_after_M", 32'(M), 32'd0);
    tick(1, 1, 5'b11111, 5'b00000);
    tick(0, 0, 5'b11111, 5'b00000);
    chk("rst_wins_M", 32'(M), 32'd0);

`ifdef RED_ITERATIVA_SERIAL_EN
    begin
      logic [4:0] ea, eb, ez;
      ea = 5'b01001;
      eb = 5'b01100;
      ez = 5'b00111;
      tick(0, 1, 5'b01001, 5'b01100);
      for (int c = 0; c < 5; c++) begin
        chk("ser_A_t", 32'(A_t), 32'(ea[4 - c]));
        chk("ser_B_t", 32'(B_t), 32'(eb[4 - c]));
        chk("ser_Z_t", 32'(Z_t), 32'(ez[4 - c]));
        chk("ser_busy", 32'(scan_busy), 32'd1);
        if (c < 4) tick(0, 0, 5'b00000, 5'b00000);
      end
      tick(0, 0, 5'b00000, 5'b00000);
      chk("ser_done", 32'(scan_busy), 32'd0);
      tick(0, 1, 5'b01001, 5'b01100);
      tick(0, 0, 5'b00000, 5'b00000);
      tick(0, 0, 5'b00000, 5'b00000);
      tick(0, 1, 5'b10110, 5'b10011);
      chk("ser_restart_A_t", 32'(A_t), 32'd1);
      for (int c = 0; c < 4; c++) tick(0, 0, 5'b00000, 5'b00000);
      chk("ser_restart_busy", 32'(scan_busy), 32'd1);
      tick(0, 0, 5'b00000, 5'b00000);
      chk("ser_restart_end", 32'(scan_busy), 32'd0);
    end
`endif

    for (int i = 0; i < 400; i++) begin
      logic r, v;
      r = ($urandom_range(0, 99) < 4);
      v = ($urandom_range(0, 99) < 60);
      tick(r, v, K'($urandom), K'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
